// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit queue feeding a UART transmitter through a start/end handshake.
// Optional UART_TX_FIFO_GAP_EN adds GAP_CYCLES idle clocks after each tx_end.
module uart_tx_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    input  logic              clr_ovf_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_busy_i,
    input  logic              tx_end_i
);

    if (DEPTH < 2 || DEPTH != (1 << ADDR_W) || GAP_CYCLES < 1) begin : gen_bad_params
        $error("uart_tx_fifo: DEPTH must be 2**ADDR_W (>= 2) and GAP_CYCLES >= 1");
    end

    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

`ifdef UART_TX_FIFO_GAP_EN
    localparam int unsigned   GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;
    logic [GapW-1:0] gap_cnt_q;
`else
    typedef enum logic [1:0] {StIdle, StWait} state_e;
`endif

    state_e            state_q;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;
    logic              push, drop, pop;

    assign full_o     = (count_q == FullCount);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

    // A dropped push is judged on the current fill, even if a pop frees a slot this cycle.
    assign push = wr_en_i && !full_o;
    assign drop = wr_en_i && full_o;
    assign pop  = (state_q == StIdle) && !empty_o && !tx_busy_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CountOne;
        end else if (!push && pop) begin
            count_d = count_q - CountOne;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
`ifdef UART_TX_FIFO_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= mem_q[rd_ptr_q];
                        state_q    <= StWait;
                    end else begin
                        tx_start_q <= 1'b0;
                    end
                end
                StWait: begin
                    tx_start_q <= 1'b0;
                    if (tx_end_i) begin
`ifdef UART_TX_FIFO_GAP_EN
                        gap_cnt_q <= GapLoad;
                        state_q   <= StGap;
`else
                        state_q   <= StIdle;
`endif
                    end
                end
`ifdef UART_TX_FIFO_GAP_EN
                StGap: begin
                    tx_start_q <= 1'b0;
                    if (gap_cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GapW'(1);
                    end
                end
`endif
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo; inputs driven and outputs sampled 1ns after
// each rising edge. Expected inter-byte latency follows UART_TX_FIFO_GAP_EN.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned GAP_CYCLES = 16;
`ifdef UART_TX_FIFO_GAP_EN
    localparam int ExpLat = GAP_CYCLES + 1;
`else
    localparam int ExpLat = 1;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              clr_ovf = 1'b0;
    logic              full, empty, overflow, tx_start;
    logic [ADDR_W:0]   count;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic              tx_end = 1'b0;

    int nvec = 0;
    int nerr = 0;

    uart_tx_fifo #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .wr_en_i(wr_en),
        .wr_data_i(wr_data),
        .clr_ovf_i(clr_ovf),
        .full_o(full),
        .empty_o(empty),
        .count_o(count),
        .overflow_o(overflow),
        .tx_start_o(tx_start),
        .tx_data_o(tx_data),
        .tx_busy_i(tx_busy),
        .tx_end_i(tx_end)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            obs = {empty, full, count, tx_start, tx_data, overflow};
            nvec++;
            if (obs !== 17'h10000) begin
                nerr++;
                $display("FAIL reset_idle cyc %0d: got %h expected %h", i, obs, 17'h10000);
            end
        end
    endtask

    task automatic test_single();
        logic bad;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        nvec++;
        if ({count, tx_start} !== {5'd1, 1'b0}) begin
            nerr++;
            $display("FAIL single_push: count/start got %h/%b expected 1/0", count, tx_start);
        end
        tick();
        nvec++;
        if ({tx_start, tx_data, count} !== {1'b1, 8'hA5, 5'd0}) begin
            nerr++;
            $display("FAIL single_launch: start/data/count got %b/%h/%h expected 1/a5/0",
                     tx_start, tx_data, count);
        end
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_start !== 1'b0 || tx_data !== 8'hA5) bad = 1'b1;
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL single_hold: extra start or data change got 1 expected 0");
        end
        tx_end = 1'b1;
        tick();
        tx_end = 1'b0;
        tick();
        nvec++;
        if ({tx_start, empty} !== 2'b01) begin
            nerr++;
            $display("FAIL single_end: start/empty got %b/%b expected 0/1", tx_start, empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int since;
        int k;
        exp_b[0] = 8'h01;
        exp_b[1] = 8'h02;
        exp_b[2] = 8'h03;
        wr_en = 1'b1;
        wr_data = 8'h01;
        tick();
        wr_data = 8'h02;
        tick();
        nvec++;
        if ({tx_start, tx_data} !== {1'b1, 8'h01}) begin
            nerr++;
            $display("FAIL b2b_first: start/data got %b/%h expected 1/01", tx_start, tx_data);
        end
        wr_data = 8'h03;
        tick();
        wr_en = 1'b0;
        since = 2;
        for (int i = 0; i < 3; i++) begin
            repeat (19 - since) tick();
            tx_end = 1'b1;
            tick();
            tx_end = 1'b0;
            if (i < 2) begin
                k = 0;
                do begin
                    tick();
                    k++;
                end while (tx_start !== 1'b1 && k < 200);
                nvec++;
                if (k != ExpLat) begin
                    nerr++;
                    $display("FAIL b2b_latency byte %0d: got %0d expected %0d", i + 1, k, ExpLat);
                end
                nvec++;
                if (tx_data !== exp_b[i+1]) begin
                    nerr++;
                    $display("FAIL b2b_data byte %0d: got %h expected %h", i + 1, tx_data,
                             exp_b[i+1]);
                end
                since = 0;
            end
        end
        tick();
        nvec++;
        if ({empty, tx_start} !== 2'b10) begin
            nerr++;
            $display("FAIL b2b_done: empty/start got %b/%b expected 1/0", empty, tx_start);
        end
    endtask

    task automatic test_overflow();
        int k;
        logic bad;
        tx_busy = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'h10 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        nvec++;
        if ({full, count, overflow, tx_start} !== {1'b1, 5'd16, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL ovf_full: full/count/ovf/start got %b/%0d/%b/%b expected 1/16/0/0",
                     full, count, overflow, tx_start);
        end
        wr_en = 1'b1;
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        nvec++;
        if ({full, count, overflow} !== {1'b1, 5'd16, 1'b1}) begin
            nerr++;
            $display("FAIL ovf_drop: full/count/ovf got %b/%0d/%b expected 1/16/1",
                     full, count, overflow);
        end
        tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            k = 0;
            do begin
                tick();
                k++;
            end while (tx_start !== 1'b1 && k < 50);
            nvec++;
            if (tx_start !== 1'b1 || tx_data !== 8'h10 + 8'(i)) begin
                nerr++;
                $display("FAIL ovf_drain byte %0d: start/data got %b/%h expected 1/%h",
                         i, tx_start, tx_data, 8'h10 + 8'(i));
            end
            tx_end = 1'b1;
            tick();
            tx_end = 1'b0;
        end
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx_start !== 1'b0) bad = 1'b1;
        end
        nvec++;
        if (bad || {empty, count} !== {1'b1, 5'd0}) begin
            nerr++;
            $display("FAIL ovf_tail: extra start/empty/count got %b/%b/%0d expected 0/1/0",
                     bad, empty, count);
        end
    endtask

    task automatic test_clr_ovf();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        nvec++;
        if (overflow !== 1'b0) begin
            nerr++;
            $display("FAIL clr_basic: got %b expected 0", overflow);
        end
        tx_busy = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_data = 8'hEE;
        clr_ovf = 1'b1;
        tick();
        wr_en = 1'b0;
        nvec++;
        if ({overflow, count} !== {1'b1, 5'd16}) begin
            nerr++;
            $display("FAIL clr_drop_wins: ovf/count got %b/%0d expected 1/16", overflow, count);
        end
        tick();
        clr_ovf = 1'b0;
        nvec++;
        if (overflow !== 1'b0) begin
            nerr++;
            $display("FAIL clr_after: got %b expected 0", overflow);
        end
        tx_busy = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hDD;
        tick();
        wr_en = 1'b0;
        nvec++;
        if ({overflow, count, tx_start, tx_data} !== {1'b1, 5'd15, 1'b1, 8'h00}) begin
            nerr++;
            $display("FAIL drop_with_pop: ovf/count/start/data got %b/%0d/%b/%h expected 1/15/1/00",
                     overflow, count, tx_start, tx_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic bad;
        tx_busy = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'h30 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        tx_busy = 1'b0;
        tick();
        nvec++;
        if ({tx_start, tx_data, count} !== {1'b1, 8'h30, 5'd5}) begin
            nerr++;
            $display("FAIL rstmid_launch: start/data/count got %b/%h/%0d expected 1/30/5",
                     tx_start, tx_data, count);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nvec++;
        if ({count, empty, tx_start, tx_data, overflow} !== {5'd0, 1'b1, 1'b0, 8'h00, 1'b0})
        begin
            nerr++;
            $display("FAIL rstmid_state: count/empty/start/data/ovf got %0d/%b/%b/%h/%b expected 0/1/0/00/0",
                     count, empty, tx_start, tx_data, overflow);
        end
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (tx_start !== 1'b0) bad = 1'b1;
        end
        tx_end = 1'b1;
        tick();
        tx_end = 1'b0;
        repeat (10) begin
            tick();
            if (tx_start !== 1'b0 || empty !== 1'b1) bad = 1'b1;
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL rstmid_quiet: spurious start or data got 1 expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_clr_ovf();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-wide transmit queue that sits directly upstream of the UART transmitter. It accepts bytes from the bus-side register logic and drives the transmitter's start/data handshake, issuing one byte at a time. It waits for the transmitter's completion pulse before issuing the next byte. It reports fill level and keeps a sticky overflow flag.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- GAP_CYCLES, 16, idle clocks inserted between bytes; used only when the optional feature is compiled in; minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  push request; sampled on rising clk
- wr_data  in  8  byte to push
- clr_ovf  in  1  clears the overflow flag
- full  out  1  high when count == DEPTH
- empty  out  1  high when count == 0
- count  out  ADDR_W+1  number of bytes held
- overflow  out  1  sticky; set when a push is dropped
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte presented to the transmitter
- tx_busy  in  1  transmitter is shifting
- tx_end  in  1  one-cycle completion pulse from the transmitter

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - Reset is synchronous and active-high: all state updates happen on the rising edge of clk, and reset is sampled there.
  - Reset values: count=0, wr_ptr=0, rd_ptr=0, overflow=0, tx_start=0, tx_data=8'h00, state=IDLE.
  - full, empty and count are combinational from registered state, so after reset empty=1 and full=0.
  - Storage contents are not reset.
- Push:
  - When wr_en=1 and full=0, write wr_data to mem[wr_ptr] and increment wr_ptr mod DEPTH.
  - When wr_en=1 and full=1, drop the byte, leave pointers unchanged and set overflow=1. This applies even if a pop occurs in the same cycle.
- Overflow flag:
  - clr_ovf=1 clears overflow.
  - If a drop and clr_ovf=1 happen in the same cycle, the drop wins and overflow=1.
- Pop: a pop occurs only on the cycle tx_start is launched, as below.
- count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged.
  - Pointers wrap silently at DEPTH.
- State machine, registered outputs:
  - IDLE: if empty=0 and tx_busy=0, set tx_start<=1, tx_data<=mem[rd_ptr], increment rd_ptr, pop, then go to WAIT. Otherwise stay in IDLE with tx_start<=0.
  - WAIT: tx_start<=0, so the pulse is exactly one cycle. tx_data holds its value. On tx_end=1, go to GAP if the optional feature is compiled in, otherwise go to IDLE.
  - GAP: load a counter with GAP_CYCLES-1 on entry and decrement it each cycle. At 0, go to IDLE.
- Latency:
  - A push into an empty FIFO at edge N gives count=1 after edge N.
  - tx_start is high during the cycle following edge N+1.
  - Back-to-back bytes: the next tx_start asserts one cycle after the cycle in which tx_end was seen (no gap build).
- tx_data stability: tx_data is stable from the tx_start cycle until the next launch.
- Corner cases:
  - tx_end seen while in IDLE or GAP is ignored.
  - tx_busy=1 in IDLE blocks launch, e.g. if the transmitter is still busy after a reset of this block.
  - Reset during WAIT or GAP discards queued bytes and the in-flight handshake; no tx_start is issued until new data is pushed.
  - A push while in WAIT is accepted normally up to DEPTH entries; the launched byte no longer counts.

Optional Feature:
- UART_TX_FIFO_GAP_EN
- Defined: the GAP state exists. Consecutive bytes are separated by GAP_CYCLES clocks after tx_end before the next tx_start, giving extra stop time for slow receivers.
- Undefined: no GAP state and no gap counter. WAIT returns directly to IDLE on tx_end.

Test Plan:
- Reset, then idle: empty=1, full=0, count=0, tx_start=0, tx_data=8'h00, overflow=0 for 10 cycles.
- Push 8'hA5 into the empty FIFO: count=1 for one cycle, then a single-cycle tx_start with tx_data=8'hA5 and count=0. Hold tx_end=0 for 50 cycles: no second tx_start.
- Push 8'h01, 8'h02, 8'h03 back-to-back; model the transmitter with tx_end pulsed 20 cycles after each tx_start. Expect tx_start pulses in order 01, 02, 03. Each pulse occurs 1 cycle after tx_end with the gap feature undefined, and GAP_CYCLES+1 cycles after tx_end with it defined.
- Hold tx_busy=1 and push DEPTH+1 bytes (16 plus 8'hFF): full=1, count=16, overflow=1. Release tx_busy: the first 16 bytes drain, and 8'hFF never appears.
- Push while full with clr_ovf=1 in the same cycle: overflow=1. Next cycle, clr_ovf=1 with no push: overflow=0.
- Assert reset in the cycle after tx_start while 5 bytes are queued: count=0, empty=1, tx_start stays 0, and a later tx_end pulse causes no launch.
